// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter with a per-bit cycle counter.
// Accepts one byte per frame and reports busy back to the upstream feeder.
module uart_tx_serializer #(
  parameter int CLK_PER_BIT = 50,
  parameter int CTR_SIZE = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       block,
  input  logic       new_data,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [CTR_SIZE-1:0] LAST = CTR_SIZE'(CLK_PER_BIT - 1);
  state_t state_q, state_d;
  logic [CTR_SIZE-1:0] ctr_q, ctr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d, busy_q, busy_d;
  logic wrap;
  assign tx = tx_q;
  assign busy = busy_q;
  assign wrap = ctr_q == LAST;
  always_comb begin
    state_d = state_q;
    ctr_d = ctr_q;
    idx_d = idx_q;
    shift_d = shift_q;
    if (state_q == IDLE) begin
      if (new_data && !block && !busy_q) begin
        shift_d = data;
        ctr_d = '0;
        idx_d = '0;
        state_d = START;
      end
    end else begin
      ctr_d = wrap ? '0 : ctr_q + CTR_SIZE'(1);
      if (wrap) begin
        case (state_q)
          START: begin
            state_d = DATA;
            idx_d = '0;
          end
          DATA: begin
            state_d = idx_q == 3'd7 ? STOP : DATA;
            idx_d = idx_q == 3'd7 ? idx_q : idx_q + 3'd1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
    // Outputs are derived from the next state so they are registered yet aligned with it.
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[idx_d] : 1'b1;
    busy_d = state_d != IDLE || block;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ctr_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q <= ctr_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed plus randomized checks of the 8N1 serializer
// against a frame model built from start/data/stop bit rules.
module tb_uart_tx_serializer;
  logic clk = 1'b0;
  logic rst, block, nd4, nd50;
  logic [7:0] data;
  logic tx4, busy4, tx50, busy50;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .block(block), .new_data(nd4), .data(data), .busy(busy4), .tx(tx4));
  uart_tx_serializer #(.CLK_PER_BIT(50)) dut50 (
    .clk(clk), .rst(rst), .block(block), .new_data(nd50), .data(data), .busy(busy50), .tx(tx50));

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_bit(input logic [7:0] d, input int k, input int n);
    int b = k / n;
    return b == 0 ? 1'b0 : b == 9 ? 1'b1 : d[b-1];
  endfunction

  // mode 0: quiet; 1: random junk strobes, data and block; 2: strobe 8'hFF at cycle 10.
  // Entered at a negedge with the DUT idle; returns at the first idle cycle after the frame.
  task automatic frame(input logic [7:0] d, input int n, input int mode, input int abort_at);
    logic [7:0] dd = d;
    data = d;
    if (n == 4) nd4 = 1'b1; else nd50 = 1'b1;
    @(negedge clk);
    nd4 = 1'b0;
    nd50 = 1'b0;
    data = 8'($urandom);
    for (int k = 0; k < 10 * n; k++) begin
      if (k == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_tx", n == 4 ? tx4 : tx50, 1'b1);
        chk("abort_busy", n == 4 ? busy4 : busy50, 1'b0);
        return;
      end
      chk($sformatf("tx_d%02h_k%0d", dd, k), n == 4 ? tx4 : tx50, model_bit(dd, k, n));
      chk($sformatf("busy_d%02h_k%0d", dd, k), n == 4 ? busy4 : busy50, 1'b1);
      if (mode == 1) begin
        nd4 = (n == 4) ? 1'($urandom) : 1'b0;
        nd50 = (n == 50) ? 1'($urandom) : 1'b0;
        data = 8'($urandom);
        block = 1'($urandom);
      end else if (mode == 2) begin
        nd4 = (n == 4) && (k == 10);
        nd50 = (n == 50) && (k == 10);
        data = k == 10 ? 8'hFF : data;
      end
      @(negedge clk);
    end
    nd4 = 1'b0;
    nd50 = 1'b0;
    chk("idle_tx", n == 4 ? tx4 : tx50, 1'b1);
    chk("idle_busy", n == 4 ? busy4 : busy50, block);
  endtask

  initial begin
    rst = 1'b0;
    block = 1'b0;
    nd4 = 1'b0;
    nd50 = 1'b0;
    data = 8'h00;
    @(negedge clk);
    chk("rst_tx4", tx4, 1'b1);
    chk("rst_busy4", busy4, 1'b0);
    chk("rst_tx50", tx50, 1'b1);
    chk("rst_busy50", busy50, 1'b0);
    rst = 1'b1;
    frame(8'h30, 4, 0, -1);
    @(negedge clk);
    frame(8'h55, 4, 2, -1);
    @(negedge clk);
    block = 1'b1;
    nd4 = 1'b1;
    data = 8'h31;
    @(negedge clk);
    nd4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("blk_tx", tx4, 1'b1);
      chk("blk_busy", busy4, 1'b1);
      @(negedge clk);
    end
    block = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk("unblk_tx", tx4, 1'b1);
      chk("unblk_busy", busy4, 1'b0);
      @(negedge clk);
    end
    frame(8'h30, 4, 0, -1);
    frame(8'h31, 4, 0, -1);
    @(negedge clk);
    frame(8'hA5, 4, 0, 17);
    @(negedge clk);
    chk("held_tx", tx4, 1'b1);
    chk("held_busy", busy4, 1'b0);
    rst = 1'b1;
    frame(8'h3C, 4, 0, -1);
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      frame(8'($urandom), 4, 1, -1);
      if (block) begin
        block = 1'b0;
        @(negedge clk);
        chk("rnd_release_busy", busy4, 1'b0);
      end
    end
    @(negedge clk);
    frame(8'h01, 50, 0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
